// File: rtl/bluetooth_uart_sender.sv
// UART sender for the BLE module: serialises a latched 16-byte ASCII command
// as 8N1 frames, byte 0 first, with an optional CR LF terminator.
module bluetooth_uart_sender #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned NUM_BYTES      = 16,
  parameter bit          APPEND_NEWLINE = 1'b1,
  parameter bit          SKIP_NUL       = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] input_data,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  // Byte index spans payload plus CR and LF (max 18), so 5 bits suffice.
  localparam int unsigned IdxW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StStartBit,
    StDataBits,
    StStopBit,
    StNextByte,
    StDone
  } state_t;

  state_t            state;
  logic [CntW-1:0]   baud;
  logic [2:0]        bit_idx;
  logic [IdxW-1:0]   byte_idx;
  logic [127:0]      shadow;
  logic [7:0]        shift;

  logic              baud_end;
  logic              advance;
  logic [31:0]       idx_ext;
  logic              sel_found;
  logic [IdxW-1:0]   sel_idx;
  logic [7:0]        sel_byte;

  assign baud_end = (baud == BaudLast);
  // Byte selection happens on NEXT_BYTE entry and directly at the end of each
  // stop bit, so consecutive frames run back to back without an idle bit.
  assign advance  = (state == StNextByte) || ((state == StStopBit) && baud_end);
  assign idx_ext  = 32'(byte_idx);

  // Find the lowest eligible byte position at or above byte_idx.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_byte  = 8'h00;
    if (APPEND_NEWLINE) begin
      if (idx_ext <= NUM_BYTES + 1) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(NUM_BYTES + 1);
        sel_byte  = 8'h0A;
      end
      if (idx_ext <= NUM_BYTES) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(NUM_BYTES);
        sel_byte  = 8'h0D;
      end
    end
    // Descending scan so the lowest qualifying payload position wins.
    for (int i = int'(NUM_BYTES) - 1; i >= 0; i--) begin
      if ((idx_ext <= 32'(i)) && !(SKIP_NUL && (shadow[8*i +: 8] == 8'h00))) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        sel_byte  = shadow[8*i +: 8];
      end
    end
  end

  // Main FSM with registered tx/busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (advance) begin
      baud    <= '0;
      bit_idx <= '0;
      if (sel_found) begin
        tx       <= 1'b0;
        shift    <= sel_byte;
        byte_idx <= sel_idx + IdxW'(1);
        state    <= StStartBit;
      end else begin
        tx    <= 1'b1;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= StDone;
      end
    end else begin
      case (state)
        StIdle: begin
          tx   <= 1'b1;
          done <= 1'b0;
          if (start) begin
            shadow   <= input_data;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= StNextByte;
          end
        end
        StStartBit: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= StDataBits;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        StDataBits: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= StStopBit;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        StStopBit: begin
          baud <= baud + 1'b1;
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/bluetooth_uart_sender.md
Name: bluetooth_uart_sender

Overview:
- Downstream stage of the Bluetooth command encoder. Takes the 128-bit packed ASCII command word, which is 16 bytes with byte 0 in bits [7:0].
- Serialises the bytes onto the UART TX line that drives the BLE module: byte 0 first, each byte as an 8N1 frame.
- Optionally appends CR LF as the AT-command terminator.
- Handshake is start/busy/done, so a controller can chain encode -> send without knowing the frame timing.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- NUM_BYTES, 16: number of payload bytes taken from input_data, starting at byte 0. Legal range is 1..16.
- APPEND_NEWLINE, 1: when 1, send 0x0D then 0x0A after the payload.
- SKIP_NUL, 0: when 1, payload bytes equal to 0x00 are dropped and no frame is sent for them. The CR LF terminator is never skipped.

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to send; sampled only in IDLE
- input_data  input  128  packed ASCII bytes; byte n = bits [8n+7:8n]
- tx  output  1  UART serial line; idles high
- busy  output  1  high while a message is in progress
- done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - tx=1, busy=0, done=0.
  - State=IDLE; baud counter, bit index and byte index cleared.
  - Reset overrides everything, including a start asserted in the same cycle.
  - Reset mid-frame aborts immediately: tx is high from the next edge and no done pulse is produced.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE, DONE.
- IDLE:
  - tx=1, busy=0.
  - On an edge with start=1: latch input_data into an internal 128-bit shadow register; byte index=0; go to NEXT_BYTE.
  - The shadow register means input_data may change at any time after the accepting edge.
- NEXT_BYTE (zero-time selection, resolved combinationally in the same cycle as entry so no idle bit time is inserted):
  - Select the next byte: payload bytes 0..NUM_BYTES-1, then 0x0D, 0x0A if APPEND_NEWLINE=1.
  - If SKIP_NUL=1 and the selected payload byte is 0x00, advance the index and reselect.
  - If no bytes remain, go to DONE. Otherwise load the byte into the shift register and enter START_BIT.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for exactly CLKS_PER_BIT cycles, then the next byte's START_BIT follows with no gap.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is accepted in the cycle after done at the earliest. A start during the DONE cycle is ignored.
- busy: registered, high from the edge after start is accepted until the edge at which done rises.
- start while busy=1 is ignored; no queuing.
- Baud counter:
  - Width ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - It is reset to 0 at every frame start, so there is no drift across bytes.
- tx is a registered output, so there is no glitching.
- Latency, with start accepted at edge E:
  - tx falls at edge E+1.
  - Total frames F = (payload bytes sent) + (2 if APPEND_NEWLINE).
  - done rises at edge E+1+10*F*CLKS_PER_BIT.
- All-bytes-skipped case (SKIP_NUL=1, payload all 0x00, APPEND_NEWLINE=0): F=0, so done rises at edge E+1 and tx never leaves 1.
- 0xFF bytes (the encoder's error fill) are transmitted normally; no special handling.

Test Plan:
- Reset and idle: hold reset 3 cycles with start=1 -> tx=1, busy=0, done=0 throughout; no frame starts.
- Full message with CLKS_PER_BIT=4, input_data = "AT+BLEUARTTX"+"abcd" (byte0=0x41) -> F=18. tx falls 1 cycle after start. Decoded bytes are 41 54 2B 42 4C 45 55 41 52 54 54 58 61 62 63 64 0D 0A. done pulses once, at 721 cycles after the start edge.
- Input changed one cycle after start to all 0xFF -> transmitted bytes still match the latched value.
- SKIP_NUL=1, NUM_BYTES=4, input_data[31:0]=0x00410042 -> only 0x42, 0x41, 0x0D, 0x0A are sent (F=4). done is at 161 cycles.
- start pulsed mid-message and again during the DONE cycle -> both ignored; exactly one message sent. A start one cycle after done starts a new message.
- reset asserted during data bit 3 of byte 5 -> tx=1 and busy=0 at the next edge; no done pulse. A subsequent start sends a complete message from byte 0.
